// File: rtl/video_dram_arb.sv
// Shared DRAM arbiter for video fetch, CPU and refresh over a fixed 8-slot window.
// Define VIDEO_DRAM_ARB_CPUSTEAL_EN to let a prioritised CPU take odd video slots.
module video_dram_arb #(
    parameter int unsigned CYC_LEN     = 4,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned REFR_PERIOD = 224
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode_bw,
    input  logic              vid_go,
    input  logic              vid_start,
    input  logic [ADDR_W-1:0] vid_base,
    input  logic              cpu_req,
    input  logic              cpu_prio,
    output logic              dram_go,
    output logic [1:0]        dram_who,
    output logic [ADDR_W-1:0] vid_addr,
    output logic              vid_strobe,
    output logic              cpu_strobe
);

    localparam int unsigned PhW = $clog2(CYC_LEN);
    localparam int unsigned RfW = $clog2(REFR_PERIOD);

    typedef enum logic [1:0] {
        OwnIdle = 2'b00,
        OwnCpu  = 2'b01,
        OwnVid  = 2'b10,
        OwnRefr = 2'b11
    } owner_e;

    logic [PhW-1:0]    phase_q, phase_d;
    logic [2:0]        slot_q, slot_d;
    logic [1:0]        bw_q, bw_d;
    owner_e            who_q, who_d;
    logic              go_q, go_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [RfW-1:0]    refr_q, refr_d;
    logic              pend_q, pend_d;

    logic       last;
    logic       refr_exp;
    logic [2:0] slot_nx;
    logic [1:0] bw_use;
    logic       vid_slot;
    logic       steal;
    owner_e     owner_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            slot_q  <= '0;
            bw_q    <= 2'b00;
            who_q   <= OwnIdle;
            go_q    <= 1'b0;
            addr_q  <= '0;
            refr_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            slot_q  <= slot_d;
            bw_q    <= bw_d;
            who_q   <= who_d;
            go_q    <= go_d;
            addr_q  <= addr_d;
            refr_q  <= refr_d;
            pend_q  <= pend_d;
        end
    end

    // Arbitration for the access that starts on the next phase-0 edge.
    always_comb begin
        last     = (phase_q == PhW'(CYC_LEN - 1));
        refr_exp = (refr_q == RfW'(REFR_PERIOD - 1));
        slot_nx  = slot_q + 3'd1;
        bw_use   = (slot_nx == 3'd0) ? mode_bw : bw_q;
        vid_slot = 1'b0;
        unique case (bw_use)
            2'b00: vid_slot = (slot_nx == 3'd0);
            2'b01: vid_slot = (slot_nx[1:0] == 2'b00);
            2'b10: vid_slot = ~slot_nx[0];
            2'b11: vid_slot = 1'b1;
        endcase
`ifdef VIDEO_DRAM_ARB_CPUSTEAL_EN
        steal = vid_slot & vid_go & slot_nx[0] & cpu_prio & cpu_req;
`else
        steal = 1'b0;
`endif
        owner_nx = OwnIdle;
        if (steal)                owner_nx = OwnCpu;
        else if (vid_slot && vid_go) owner_nx = OwnVid;
        else if (pend_q)          owner_nx = OwnRefr;
        else if (cpu_req)         owner_nx = OwnCpu;
    end

`ifndef VIDEO_DRAM_ARB_CPUSTEAL_EN
    logic unused_cpu_prio;
    assign unused_cpu_prio = cpu_prio;
`endif

    always_comb begin
        phase_d = last ? '0 : phase_q + PhW'(1);
        refr_d  = refr_exp ? '0 : refr_q + RfW'(1);
        slot_d  = slot_q;
        bw_d    = bw_q;
        who_d   = who_q;
        go_d    = 1'b0;
        pend_d  = pend_q;
        addr_d  = addr_q;
        if (last) begin
            slot_d = slot_nx;
            if (slot_nx == 3'd0) bw_d = mode_bw;
            who_d = owner_nx;
            go_d  = 1'b1;
            if (owner_nx == OwnRefr) pend_d = 1'b0;
        end
        // An expiry on the same edge as a refresh grant starts a fresh period.
        if (refr_exp) pend_d = 1'b1;
        if (last && who_q == OwnVid) addr_d = addr_q + ADDR_W'(1);
        if (vid_start) addr_d = vid_base;
    end

    always_comb begin
        dram_go    = go_q;
        dram_who   = who_q;
        vid_addr   = addr_q;
        vid_strobe = last && (who_q == OwnVid);
        cpu_strobe = last && (who_q == OwnCpu);
    end

endmodule

// File: tb/tb_video_dram_arb.sv
// Randomised bench for video_dram_arb against a clock-count based reference model.
module tb_video_dram_arb;

    localparam int CYC = 4;
    localparam int AW  = 16;
    localparam int RP  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode_bw;
    logic          vid_go, vid_start, cpu_req, cpu_prio;
    logic [AW-1:0] vid_base;
    logic          dram_go, vid_strobe, cpu_strobe;
    logic [1:0]    dram_who;
    logic [AW-1:0] vid_addr;

    int total = 0;
    int bad   = 0;

    video_dram_arb #(.CYC_LEN(CYC), .ADDR_W(AW), .REFR_PERIOD(RP)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode_bw    (mode_bw),
        .vid_go     (vid_go),
        .vid_start  (vid_start),
        .vid_base   (vid_base),
        .cpu_req    (cpu_req),
        .cpu_prio   (cpu_prio),
        .dram_go    (dram_go),
        .dram_who   (dram_who),
        .vid_addr   (vid_addr),
        .vid_strobe (vid_strobe),
        .cpu_strobe (cpu_strobe)
    );

    always #5 clk = ~clk;

    // Reference model: m_t counts clocks since reset; phase, slot and refresh
    // timing all follow arithmetically from it.
    int            m_t;
    bit            m_pend;
    logic [1:0]    m_bw;
    logic [1:0]    m_owner;
    logic [AW-1:0] m_addr;
    bit            m_go;
    bit            cs_now, cs_prev;

    function automatic bit in_mask(int s, logic [1:0] bw);
        case (bw)
            2'd0:    return s == 0;
            2'd1:    return (s % 4) == 0;
            2'd2:    return (s % 2) == 0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit steal_ok(int s);
`ifdef VIDEO_DRAM_ARB_CPUSTEAL_EN
        return (s % 2 == 1) && cpu_prio && cpu_req;
`else
        return (s < 0);
`endif
    endfunction

    function automatic int cur_slot();
        return (m_t / CYC) % 8;
    endfunction

    function automatic bit exp_vs();
        return (m_t % CYC == CYC - 1) && (m_owner == 2'b10);
    endfunction

    function automatic bit exp_cs();
        return (m_t % CYC == CYC - 1) && (m_owner == 2'b01);
    endfunction

    task automatic model_step();
        int s;
        bit last, expire, vs;
        logic [1:0] own;
        if (rst) begin
            m_t = 0; m_pend = 0; m_bw = 2'd0; m_owner = 2'd0; m_addr = '0; m_go = 0;
            return;
        end
        last   = (m_t % CYC) == CYC - 1;
        expire = (m_t % RP) == RP - 1;
        m_go   = 0;
        if (last && m_owner == 2'b10) m_addr = m_addr + 1'b1;
        if (vid_start) m_addr = vid_base;
        if (last) begin
            s = ((m_t + 1) / CYC) % 8;
            if (s == 0) m_bw = mode_bw;
            vs = in_mask(s, m_bw) && vid_go;
            if (vs && steal_ok(s)) own = 2'b01;
            else if (vs)           own = 2'b10;
            else if (m_pend)       own = 2'b11;
            else if (cpu_req)      own = 2'b01;
            else                   own = 2'b00;
            if (own == 2'b11) m_pend = 0;
            m_owner = own;
            m_go    = 1;
        end
        if (expire) m_pend = 1;
        m_t++;
    endtask

    task automatic check_all();
        total += 5;
        assert (dram_go === m_go) else begin
            bad++; $error("FAIL dram_go got=%0b want=%0b t=%0d", dram_go, m_go, m_t);
        end
        assert (dram_who === m_owner) else begin
            bad++; $error("FAIL dram_who got=%0d want=%0d t=%0d", dram_who, m_owner, m_t);
        end
        assert (vid_addr === m_addr) else begin
            bad++; $error("FAIL vid_addr got=%h want=%h t=%0d", vid_addr, m_addr, m_t);
        end
        assert (vid_strobe === exp_vs()) else begin
            bad++; $error("FAIL vid_strobe got=%0b want=%0b t=%0d", vid_strobe, exp_vs(), m_t);
        end
        assert (cpu_strobe === exp_cs()) else begin
            bad++; $error("FAIL cpu_strobe got=%0b want=%0b t=%0d", cpu_strobe, exp_cs(), m_t);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        cs_prev = cs_now;
        cs_now  = exp_cs();
    endtask

    task automatic check_delta(string tag, logic [AW-1:0] got, logic [AW-1:0] want);
        total++;
        assert (got === want) else begin
            bad++; $error("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    logic [AW-1:0] a0;
    int            n;

    initial begin
        rst = 1; mode_bw = 0; vid_go = 0; vid_start = 0; vid_base = '0;
        cpu_req = 0; cpu_prio = 0; cs_now = 0; cs_prev = 0;

        // Reset for three clocks, then the first access starts four clocks later.
        repeat (3) tick();
        rst = 0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total++;
            assert (dram_go === (i == 4)) else begin
                bad++; $error("FAIL first_go clk=%0d got=%0b want=%0b", i, dram_go, i == 4);
            end
        end
        total++;
        assert (dram_who === 2'b00) else begin
            bad++; $error("FAIL first_who got=%0d want=0", dram_who);
        end
        repeat (8) tick();

        // Quarter bandwidth with a busy CPU: two video accesses per 8.
        mode_bw = 2'd1; vid_go = 1; cpu_req = 1;
        repeat (64) tick();
        a0 = vid_addr;
        repeat (8 * CYC) tick();
        check_delta("bw01_window", vid_addr, a0 + 16'd2);

        // Switch 00 -> 11 in slot 3; full bandwidth only from the next window.
        mode_bw = 2'd0; cpu_req = 0;
        repeat (64) tick();
        n = 0;
        while (!(cur_slot() == 3) && n < 200) begin tick(); n++; end
        mode_bw = 2'd3;
        n = 0;
        while (!(cur_slot() == 0 && m_t % CYC == 0) && n < 200) begin tick(); n++; end
        total++;
        assert (n < 200) else begin bad++; $error("FAIL wait_slot0 got=%0d want<200", n); end
        a0 = vid_addr;
        repeat (8 * CYC) tick();
        check_delta("bw11_window", vid_addr, a0 + 16'd8);

        // Refresh starved while video owns every slot, granted once vid_go drops.
        repeat (64) tick();
        vid_go = 0;
        repeat (64) tick();

        // vid_start on a strobe edge overrides the increment.
        vid_go = 1;
        n = 0;
        while (!exp_vs() && n < 200) begin tick(); n++; end
        vid_start = 1; vid_base = 16'h4000;
        tick();
        vid_start = 0;
        check_delta("start_override", vid_addr, 16'h4000);

        // Randomised traffic obeying the CPU handshake, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            mode_bw   = 2'($urandom_range(0, 3));
            vid_go    = ($urandom_range(0, 3) != 0);
            vid_start = ($urandom_range(0, 40) == 0);
            vid_base  = 16'($urandom);
            cpu_prio  = $urandom_range(0, 1) == 1;
            rst       = ($urandom_range(0, 600) == 0);
            if (cpu_req) begin
                if (cs_prev && $urandom_range(0, 1) == 1) cpu_req = 0;
            end else begin
                cpu_req = ($urandom_range(0, 2) == 0);
            end
            tick();
        end
        rst = 0; vid_start = 0;

        // CPU-priority stealing of odd slots at full bandwidth.
        mode_bw = 2'd3; vid_go = 1; cpu_prio = 1; cpu_req = 1;
        repeat (64) tick();
        a0 = vid_addr;
        repeat (8 * CYC) tick();
`ifdef VIDEO_DRAM_ARB_CPUSTEAL_EN
        check_delta("steal_window", vid_addr, a0 + 16'd4);
`else
        check_delta("steal_window", vid_addr, a0 + 16'd8);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_dram_arb.md
Name: video_dram_arb

Overview:
- Schedules the shared DRAM between video fetch, Z80 (CPU) accesses and refresh.
- Fixed 8-slot window; video fetch share taken from the decoded bandwidth code mode_bw (00=1/8, 01=1/4, 10=1/2, 11=1).
- Owns the video fetch address counter and produces the per-access go/strobe pulses consumed by the DRAM controller and the video fetcher.

Parameters:
- CYC_LEN, 4, clk cycles per DRAM access (power of 2, >=2)
- ADDR_W, 16, width of video fetch address counter
- REFR_PERIOD, 224, clk cycles between refresh requests

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- mode_bw  in  2  video bandwidth code from mode decoder
- vid_go  in  1  video fetch window active (visible area)
- vid_start  in  1  pulse: reload video address (frame start)
- vid_base  in  ADDR_W  address loaded on vid_start
- cpu_req  in  1  CPU access request, held until cpu_strobe
- cpu_prio  in  1  CPU may steal video slots (used only with optional feature)
- dram_go  out  1  pulse: new DRAM access starts
- dram_who  out  2  current owner: 00 idle, 01 cpu, 10 video, 11 refresh
- vid_addr  out  ADDR_W  video address of current/next video access
- vid_strobe  out  1  pulse: video data valid
- cpu_strobe  out  1  pulse: CPU access complete

Behaviour:
- Reset (rst=1 at a clk edge): phase=0, slot=0, bw_lat=00, dram_who=00, dram_go=0, vid_strobe=0, cpu_strobe=0, vid_addr=0, refresh pending=0, refresh counter=0. Reset mid-access aborts it; no strobe is issued.
- Phase counter 0..CYC_LEN-1 free-runs.
  - At phase CYC_LEN-1, the arbitration decision is registered for the next access.
  - The next clock is phase 0 of the new access: dram_go=1 for exactly that one clk, and dram_who holds the owner for the whole access.
- Slot counter 0..7 increments (wraps 7->0) at each access start.
  - mode_bw is latched into bw_lat only when the new slot is 0. A mid-window change takes effect at the next window.
- Video slot mask by bw_lat (s = slot number of the upcoming access):
  - 00: s=0
  - 01: s in {0,4}
  - 10: s even
  - 11: every slot
- Arbitration priority for the upcoming access:
  1. Video, if the slot is a video slot and vid_go=1.
  2. Refresh, if pending.
  3. CPU, if cpu_req=1.
  4. Otherwise idle.
- A video slot with vid_go=0 is free for refresh or CPU.
- Refresh counter counts clk cycles.
  - At REFR_PERIOD-1 it wraps to 0 and sets pending.
  - pending clears when a refresh access starts.
  - A new period expiring while pending is already set is lost, not queued.
- cpu_strobe=1 for one clk at phase CYC_LEN-1 of a CPU access.
  - The same edge may grant the next access to the CPU only if cpu_req is still 1. The requester deasserts in the cycle after the strobe when done.
- vid_strobe=1 for one clk at phase CYC_LEN-1 of a video access.
  - vid_addr increments by 1 (modulo 2^ADDR_W) on the same edge.
- vid_start:
  - Loads vid_base into vid_addr on that edge.
  - Overrides a simultaneous increment.
  - Has no effect on the slot or phase counters.
- Idle access: dram_go still pulses with dram_who=00; no strobes.

Optional Feature:
- Macro: VIDEO_DRAM_ARB_CPUSTEAL_EN
- Defined: a video slot whose number is odd goes to the CPU when cpu_prio=1 and cpu_req=1. The stolen slot does not advance vid_addr. Slot 0 and all even slots are never stolen.
- Undefined: cpu_prio is ignored and video always wins its slots.

Test Plan:
- rst held 3 clk, then released, REFR_PERIOD large, no requests -> first dram_go 4 clk after release, dram_who=00, all strobes 0, vid_addr=0.
- mode_bw=01, vid_go=1, cpu_req held 1 -> per 8-access window, dram_who=10 at slots 0 and 4 and 01 at the other 6; vid_addr +2 per window; 6 cpu_strobe pulses per window.
- mode_bw changes 00->11 at slot 3 with vid_go=1 -> slots 4-7 still follow the 00 mask; from the next slot 0 all 8 accesses are video, vid_addr +8 per window.
- REFR_PERIOD=16, mode_bw=11, vid_go=1 -> no refresh while vid_go=1; drop vid_go -> refresh is granted at the next access start, pending clears, at most one refresh per expiry.
- vid_start with vid_base=0x4000 on the same clk as a vid_strobe -> vid_addr=0x4000, not 0x4001.
- With VIDEO_DRAM_ARB_CPUSTEAL_EN, mode_bw=11, vid_go=1, cpu_prio=1, cpu_req=1 -> odd slots are 01, even slots 10, vid_addr +4 per window; with the macro undefined, all slots are 10.
